// File: rtl/package_collector.sv
// rtl/package_collector.sv - frames package energy words into a FIFO stream and checks package integrity
//
// Purpose: after each get_package strobe, forwards the 1024 energy words to a
// FIFO write port with sof/eof markers, checks the 6 trailer words, the
// declared length and event-number continuity, and reports one pkg_done
// strobe with a status vector per package.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   get_package         one-cycle header-found strobe
//   r_pkglength .. r_evtno  decoded header fields, valid with get_package
//   data_in             aligned word stream
//   fifo_full           downstream FIFO full
//   out_valid/out_data/out_sof/out_eof   FIFO write port
//   pkg_done, pkg_status, pkg_evtno/spillno/slotno/timestamp  package close report
//   pkg_count, err_count  running counters
module package_collector #(
  parameter int N_ENERGY       = 1024,
  parameter int N_TRAILER      = 6,
  parameter int PACKAGE_LENGTH = 1036
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        get_package,
  input  logic [15:0] r_pkglength,
  input  logic [28:0] r_timestamp,
  input  logic [8:0]  r_spillno,
  input  logic [4:0]  r_slotno,
  input  logic [13:0] r_evtno,
  input  logic [15:0] data_in,
  input  logic        fifo_full,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        pkg_done,
  output logic [5:0]  pkg_status,
  output logic [13:0] pkg_evtno,
  output logic [8:0]  pkg_spillno,
  output logic [4:0]  pkg_slotno,
  output logic [28:0] pkg_timestamp,
  output logic [15:0] pkg_count,
  output logic [15:0] err_count
);

  localparam logic [10:0] LP_E_LAST = 11'(N_ENERGY - 1);
  localparam logic [10:0] LP_T_LAST = 11'(N_TRAILER - 1);

  typedef enum logic [1:0] {S_IDLE, S_ENERGY, S_TRAILER} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [10:0] r_word_cnt;

  logic [13:0] r_hdr_evtno;
  logic [8:0]  r_hdr_spillno;
  logic [4:0]  r_hdr_slotno;
  logic [28:0] r_hdr_timestamp;

  logic        r_tag_err;
  logic        r_trl_err;
  logic        r_ovf;
  logic        r_len_err;
  logic        r_evt_skip;

  logic [13:0] r_prev_evtno;
  logic [8:0]  r_prev_spillno;
  logic        r_prev_valid;

  logic        w_close;
  logic        w_trunc;
  logic        w_fwd;
  logic        w_trl_chk;
  logic        w_tag_bad;
  logic        w_trl_bad;
  logic        w_skip;
  logic [13:0] w_evt_expect;
  logic [5:0]  w_status;

  assign w_tag_bad    = (data_in[15:14] != 2'b10);
  assign w_trl_bad    = (data_in[15:14] != 2'b01);
  assign w_evt_expect = r_prev_evtno + 14'd1;
  assign w_skip       = r_prev_valid && (r_spillno == r_prev_spillno) && (r_evtno != w_evt_expect);

  always_comb begin
    w_next_state = r_state;
    w_close      = 1'b0;
    w_trunc      = 1'b0;
    w_fwd        = 1'b0;
    w_trl_chk    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (get_package) w_next_state = S_ENERGY;
      end
      S_ENERGY: begin
        // A header mid-package aborts the open package; that cycle's word is not forwarded.
        if (get_package) begin
          w_close = 1'b1;
          w_trunc = 1'b1;
        end else begin
          w_fwd = 1'b1;
          if (r_word_cnt == LP_E_LAST) w_next_state = S_TRAILER;
        end
      end
      S_TRAILER: begin
        if (r_word_cnt == LP_T_LAST) begin
          // Normal close; a coincident header starts the next package with no gap.
          w_close      = 1'b1;
          w_trl_chk    = 1'b1;
          w_next_state = get_package ? S_ENERGY : S_IDLE;
        end else if (get_package) begin
          w_close      = 1'b1;
          w_trunc      = 1'b1;
          w_next_state = S_ENERGY;
        end else begin
          w_trl_chk = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // The last trailer word's check folds straight into the reported status.
  assign w_status = {r_evt_skip, r_len_err, r_ovf, w_trunc,
                     r_trl_err | (w_trl_chk & w_trl_bad), r_tag_err};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_word_cnt      <= '0;
      r_hdr_evtno     <= '0;
      r_hdr_spillno   <= '0;
      r_hdr_slotno    <= '0;
      r_hdr_timestamp <= '0;
      r_tag_err       <= 1'b0;
      r_trl_err       <= 1'b0;
      r_ovf           <= 1'b0;
      r_len_err       <= 1'b0;
      r_evt_skip      <= 1'b0;
      r_prev_evtno    <= '0;
      r_prev_spillno  <= '0;
      r_prev_valid    <= 1'b0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_sof         <= 1'b0;
      out_eof         <= 1'b0;
      pkg_done        <= 1'b0;
      pkg_status      <= '0;
      pkg_evtno       <= '0;
      pkg_spillno     <= '0;
      pkg_slotno      <= '0;
      pkg_timestamp   <= '0;
      pkg_count       <= '0;
      err_count       <= '0;
    end else begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      pkg_done  <= 1'b0;

      if (w_fwd) begin
        out_data <= data_in;
        if (w_tag_bad) r_tag_err <= 1'b1;
        // A dropped word takes its sof/eof marker with it.
        if (fifo_full) begin
          r_ovf <= 1'b1;
        end else begin
          out_valid <= 1'b1;
          out_sof   <= (r_word_cnt == 11'd0);
          out_eof   <= (r_word_cnt == LP_E_LAST);
        end
      end

      if (w_trl_chk && w_trl_bad) r_trl_err <= 1'b1;

      if (w_fwd && (r_word_cnt == LP_E_LAST)) r_word_cnt <= '0;
      else if (r_state != S_IDLE)            r_word_cnt <= r_word_cnt + 11'd1;

      if (w_close) begin
        pkg_done      <= 1'b1;
        pkg_status    <= w_status;
        pkg_evtno     <= r_hdr_evtno;
        pkg_spillno   <= r_hdr_spillno;
        pkg_slotno    <= r_hdr_slotno;
        pkg_timestamp <= r_hdr_timestamp;
        pkg_count     <= pkg_count + 16'd1;
        if ((|w_status) && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
      end

      // Start of a new package overrides the flag updates above.
      if (get_package) begin
        r_hdr_evtno     <= r_evtno;
        r_hdr_spillno   <= r_spillno;
        r_hdr_slotno    <= r_slotno;
        r_hdr_timestamp <= r_timestamp;
        r_len_err       <= (r_pkglength != 16'(PACKAGE_LENGTH));
        r_evt_skip      <= w_skip;
        r_tag_err       <= 1'b0;
        r_trl_err       <= 1'b0;
        r_ovf           <= 1'b0;
        r_word_cnt      <= '0;
        r_prev_evtno    <= r_evtno;
        r_prev_spillno  <= r_spillno;
        r_prev_valid    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_package_collector.sv
// tb/tb_package_collector.sv - self-checking bench for package_collector
module tb_package_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        get_package;
  logic [15:0] r_pkglength;
  logic [28:0] r_timestamp;
  logic [8:0]  r_spillno;
  logic [4:0]  r_slotno;
  logic [13:0] r_evtno;
  logic [15:0] data_in;
  logic        fifo_full;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_sof;
  logic        out_eof;
  logic        pkg_done;
  logic [5:0]  pkg_status;
  logic [13:0] pkg_evtno;
  logic [8:0]  pkg_spillno;
  logic [4:0]  pkg_slotno;
  logic [28:0] pkg_timestamp;
  logic [15:0] pkg_count;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  package_collector dut (
    .clk(clk), .rst_n(rst_n), .get_package(get_package),
    .r_pkglength(r_pkglength), .r_timestamp(r_timestamp), .r_spillno(r_spillno),
    .r_slotno(r_slotno), .r_evtno(r_evtno), .data_in(data_in), .fifo_full(fifo_full),
    .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
    .pkg_done(pkg_done), .pkg_status(pkg_status), .pkg_evtno(pkg_evtno),
    .pkg_spillno(pkg_spillno), .pkg_slotno(pkg_slotno), .pkg_timestamp(pkg_timestamp),
    .pkg_count(pkg_count), .err_count(err_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int          mon_valid = 0;
  int          mon_sof   = 0;
  int          mon_eof   = 0;
  int          mon_done  = 0;
  int          mon_c011  = 0;
  logic [15:0] mon_sof_data = '0;
  logic [15:0] mon_eof_data = '0;
  logic [5:0]  done_status[$];
  logic [13:0] done_evt[$];

  always @(negedge clk) begin
    if (out_valid) begin
      mon_valid++;
      if (out_data == 16'hC011) mon_c011++;
      if (out_sof) begin mon_sof++; mon_sof_data = out_data; end
      if (out_eof) begin mon_eof++; mon_eof_data = out_data; end
    end
    if (pkg_done) begin
      mon_done++;
      done_status.push_back(pkg_status);
      done_evt.push_back(pkg_evtno);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [28:0] ts_of(input logic [13:0] evt);
    return {6'h15, 9'h000, evt};
  endfunction

  task automatic set_hdr(input logic [13:0] evt, input logic [8:0] spill, input logic [15:0] len);
    r_evtno     = evt;
    r_spillno   = spill;
    r_slotno    = spill[4:0];
    r_pkglength = len;
    r_timestamp = ts_of(evt);
  endtask

  task automatic drive_pkg(input logic [13:0] evt, input logic [8:0] spill, input logic [15:0] len,
                           input int n_e, input int tag_idx, input int trl_idx,
                           input int full_lo, input int full_hi,
                           input bit do_trailer, input bit skip_hdr, input bit b2b,
                           input logic [13:0] nevt, input logic [8:0] nspill);
    if (!skip_hdr) begin
      set_hdr(evt, spill, len);
      get_package = 1'b1;
      tick();
      get_package = 1'b0;
    end
    for (int i = 0; i < n_e; i++) begin
      data_in   = (i == tag_idx) ? 16'hC011 : 16'(32'h8000 + i);
      fifo_full = (i >= full_lo) && (i <= full_hi);
      tick();
    end
    fifo_full = 1'b0;
    if (do_trailer) begin
      for (int t = 0; t < 6; t++) begin
        data_in = (t == trl_idx) ? 16'h0000 : 16'h4000;
        if (t == 5 && b2b) begin
          set_hdr(nevt, nspill, 16'd1036);
          get_package = 1'b1;
        end
        tick();
      end
    end
    get_package = 1'b0;
    data_in     = '0;
  endtask

  typedef struct {
    logic [13:0] evt;
    logic [8:0]  spill;
    logic [15:0] len;
    int          tag_idx;
    int          trl_idx;
    int          full_lo;
    int          full_hi;
    logic [5:0]  exp_status;
    int          exp_valid;
    int          exp_sof;
    int          exp_eof;
  } vec_t;

  vec_t vecs[11];
  int   exp_pkg = 0;
  int   exp_err = 0;

  initial begin
    int v0, s0, e0, d0, c0, qi;

    vecs[0]  = '{14'd5,     9'd3, 16'd1036, -1, -1, -1,   -1,   6'b000000, 1024, 1, 1};
    vecs[1]  = '{14'd7,     9'd3, 16'd1036, -1, -1, -1,   -1,   6'b100000, 1024, 1, 1};
    vecs[2]  = '{14'd8,     9'd3, 16'd1036, 17,  2, -1,   -1,   6'b000011, 1024, 1, 1};
    vecs[3]  = '{14'd9,     9'd4, 16'd1036, -1, -1, -1,   -1,   6'b000000, 1024, 1, 1};
    vecs[4]  = '{14'h3FFE,  9'd4, 16'd1036, -1, -1, -1,   -1,   6'b100000, 1024, 1, 1};
    vecs[5]  = '{14'h3FFF,  9'd4, 16'd1036, -1, -1, -1,   -1,   6'b000000, 1024, 1, 1};
    vecs[6]  = '{14'h0000,  9'd4, 16'd1036, -1, -1, -1,   -1,   6'b000000, 1024, 1, 1};
    vecs[7]  = '{14'd1,     9'd4, 16'd1036, -1, -1, 10,   12,   6'b001000, 1021, 1, 1};
    vecs[8]  = '{14'd2,     9'd4, 16'd1035, -1, -1, -1,   -1,   6'b010000, 1024, 1, 1};
    vecs[9]  = '{14'd3,     9'd4, 16'd1036, -1, -1,  0,    0,   6'b001000, 1023, 0, 1};
    vecs[10] = '{14'd4,     9'd4, 16'd1036, -1, -1, 1023, 1023, 6'b001000, 1023, 1, 0};

    rst_n = 1'b0; get_package = 1'b0; data_in = '0; fifo_full = 1'b0;
    set_hdr('0, '0, '0);
    repeat (3) tick();
    @(negedge clk);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_done", 32'(pkg_done), 32'd0);
    chk("reset_pkg_count", 32'(pkg_count), 32'd0);
    chk("reset_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int r = 0; r < 11; r++) begin
      v0 = mon_valid; s0 = mon_sof; e0 = mon_eof; d0 = mon_done; c0 = mon_c011;
      drive_pkg(vecs[r].evt, vecs[r].spill, vecs[r].len, 1024, vecs[r].tag_idx, vecs[r].trl_idx,
                vecs[r].full_lo, vecs[r].full_hi, 1'b1, 1'b0, 1'b0, '0, '0);
      exp_pkg++;
      if (vecs[r].exp_status != 6'b0) exp_err++;
      @(negedge clk);
      chk($sformatf("row%0d_done", r), 32'(pkg_done), 32'd1);
      chk($sformatf("row%0d_status", r), 32'(pkg_status), 32'(vecs[r].exp_status));
      chk($sformatf("row%0d_evtno", r), 32'(pkg_evtno), 32'(vecs[r].evt));
      chk($sformatf("row%0d_spillno", r), 32'(pkg_spillno), 32'(vecs[r].spill));
      chk($sformatf("row%0d_slotno", r), 32'(pkg_slotno), 32'(vecs[r].spill[4:0]));
      chk($sformatf("row%0d_timestamp", r), 32'(pkg_timestamp), 32'(ts_of(vecs[r].evt)));
      chk($sformatf("row%0d_pkg_count", r), 32'(pkg_count), 32'(exp_pkg));
      chk($sformatf("row%0d_err_count", r), 32'(err_count), 32'(exp_err));
      repeat (2) tick();
      chk($sformatf("row%0d_valid_cnt", r), 32'(mon_valid - v0), 32'(vecs[r].exp_valid));
      chk($sformatf("row%0d_sof_cnt", r), 32'(mon_sof - s0), 32'(vecs[r].exp_sof));
      chk($sformatf("row%0d_eof_cnt", r), 32'(mon_eof - e0), 32'(vecs[r].exp_eof));
      chk($sformatf("row%0d_done_cnt", r), 32'(mon_done - d0), 32'd1);
      chk($sformatf("row%0d_c011_fwd", r), 32'(mon_c011 - c0), (vecs[r].tag_idx >= 0) ? 32'd1 : 32'd0);
      if (vecs[r].exp_sof != 0) chk($sformatf("row%0d_sof_data", r), 32'(mon_sof_data), 32'h8000);
      if (vecs[r].exp_eof != 0) chk($sformatf("row%0d_eof_data", r), 32'(mon_eof_data), 32'h83FF);
    end

    // Truncation after energy word 500, then a clean package.
    v0 = mon_valid; s0 = mon_sof; e0 = mon_eof; d0 = mon_done; qi = done_status.size();
    drive_pkg(14'd10, 9'd5, 16'd1036, 501, -1, -1, -1, -1, 1'b0, 1'b0, 1'b0, '0, '0);
    drive_pkg(14'd11, 9'd5, 16'd1036, 1024, -1, -1, -1, -1, 1'b1, 1'b0, 1'b0, '0, '0);
    exp_pkg += 2; exp_err += 1;
    repeat (2) tick();
    chk("trunc_done_cnt", 32'(mon_done - d0), 32'd2);
    if (done_status.size() >= qi + 2) begin
      chk("trunc_status", 32'(done_status[qi]), 32'b000100);
      chk("trunc_evtno", 32'(done_evt[qi]), 32'd10);
      chk("after_trunc_status", 32'(done_status[qi+1]), 32'd0);
      chk("after_trunc_evtno", 32'(done_evt[qi+1]), 32'd11);
    end
    chk("trunc_valid_cnt", 32'(mon_valid - v0), 32'd1525);
    chk("trunc_sof_cnt", 32'(mon_sof - s0), 32'd2);
    chk("trunc_eof_cnt", 32'(mon_eof - e0), 32'd1);
    chk("trunc_pkg_count", 32'(pkg_count), 32'(exp_pkg));
    chk("trunc_err_count", 32'(err_count), 32'(exp_err));

    // Back-to-back header on the closing trailer cycle.
    v0 = mon_valid; e0 = mon_eof; d0 = mon_done; qi = done_status.size();
    drive_pkg(14'd12, 9'd5, 16'd1036, 1024, -1, -1, -1, -1, 1'b1, 1'b0, 1'b1, 14'd13, 9'd5);
    drive_pkg(14'd13, 9'd5, 16'd1036, 1024, -1, -1, -1, -1, 1'b1, 1'b1, 1'b0, '0, '0);
    exp_pkg += 2;
    repeat (2) tick();
    chk("b2b_done_cnt", 32'(mon_done - d0), 32'd2);
    if (done_status.size() >= qi + 2) begin
      chk("b2b_status0", 32'(done_status[qi]), 32'd0);
      chk("b2b_status1", 32'(done_status[qi+1]), 32'd0);
      chk("b2b_evtno1", 32'(done_evt[qi+1]), 32'd13);
    end
    chk("b2b_valid_cnt", 32'(mon_valid - v0), 32'd2048);
    chk("b2b_eof_cnt", 32'(mon_eof - e0), 32'd2);
    chk("b2b_pkg_count", 32'(pkg_count), 32'(exp_pkg));

    // Reset at energy word 300, with a header strobe inside the reset cycle.
    v0 = mon_valid; d0 = mon_done;
    drive_pkg(14'd14, 9'd5, 16'd1036, 300, -1, -1, -1, -1, 1'b0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    set_hdr(14'd30, 9'd5, 16'd1036);
    get_package = 1'b1;
    data_in = 16'h8000;
    tick();
    rst_n = 1'b1; get_package = 1'b0; data_in = '0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_sof_eof", 32'({out_sof, out_eof}), 32'd0);
    chk("rst_pkg_done", 32'(pkg_done), 32'd0);
    chk("rst_pkg_status", 32'(pkg_status), 32'd0);
    chk("rst_pkg_hdr", 32'(|{pkg_evtno, pkg_spillno, pkg_slotno, pkg_timestamp}), 32'd0);
    chk("rst_pkg_count", 32'(pkg_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    repeat (5) tick();
    chk("rst_valid_cnt", 32'(mon_valid - v0), 32'd300);
    chk("rst_no_done", 32'(mon_done - d0), 32'd0);
    drive_pkg(14'd20, 9'd5, 16'd1036, 1024, -1, -1, -1, -1, 1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("post_rst_done", 32'(pkg_done), 32'd1);
    chk("post_rst_status", 32'(pkg_status), 32'd0);
    chk("post_rst_evtno", 32'(pkg_evtno), 32'd20);
    chk("post_rst_pkg_count", 32'(pkg_count), 32'd1);
    chk("post_rst_err_count", 32'(err_count), 32'd0);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
